ws2812_src_arb: RTL and testbench
=================================

Name: ws2812_src_arb

Overview:
- Parametrised N-source arbiter between per-mode WS2812 frame generators (menu, draw, future modes) and the single ws2812_ctrl serialiser.
- Routes debounced keys only to the active source.
- Muxes start/num/data from the active source to the controller.
- Changes source only at a frame boundary, optionally inserting an all-off blank frame so no frame ever mixes pixels from two sources.

Parameters:
- NUM_SRC, 4, number of frame sources; mode codes 0..NUM_SRC-1; codes >= NUM_SRC mean "no source".
- SEL_W, 2, width of mode code; must satisfy 2**SEL_W >= NUM_SRC.
- NUM_W, 6, pixel index width (cfg_num).
- DATA_W, 24, pixel colour width (GRB).
- KEY_W, 5, key vector width.
- LED_NUM, 64, pixels per frame, used by the blank frame.
- BLANK_EN, 1, 1 = insert a blank frame on every source change.
- FRAME_TO, 2**20, maximum cycles to wait for frame_done before forcing the boundary.

Ports:
- sys_clk, in, 1, system clock.
- sys_rst, in, 1, synchronous active-high reset.
- mode_req, in, SEL_W, requested source code; level, may change at any time.
- key_in, in, KEY_W, one-cycle key pulses from FSM_KEY.
- src_start, in, NUM_SRC, per-source frame start request, bit i = source i.
- src_num, in, NUM_SRC*NUM_W, per-source pixel index; source i in slice [i*NUM_W +: NUM_W].
- src_data, in, NUM_SRC*DATA_W, per-source pixel colour, same slicing.
- cfg_start, in, 1, pixel data request pulse from ws2812_ctrl.
- frame_done, in, 1, pulse from ws2812_ctrl after the last pixel of a frame is shifted out.
- src_cfg_start, out, NUM_SRC, cfg_start forwarded to the active source only.
- src_key, out, NUM_SRC*KEY_W, keys forwarded to the active source only.
- ws2812_start, out, 1, frame start to ws2812_ctrl.
- cfg_num, out, NUM_W, pixel index to ws2812_ctrl.
- cfg_data, out, DATA_W, pixel colour to ws2812_ctrl.
- mode_cur, out, SEL_W, currently active source code.
- switching, out, 1, high while a source change is pending or in progress.

Behaviour:
- Reset, synchronous:
  - state RUN; mode_cur = 0; switching = 0.
  - All other outputs 0.
  - frame_active = 0; blank counter = 0; timeout counter = 0.
- Muxing in RUN, one registered stage:
  - cfg_num, cfg_data and ws2812_start equal the active source's signals delayed by 1 cycle.
  - src_key slice [mode_cur] = key_in delayed by 1 cycle; all other slices 0.
  - src_cfg_start: combinational AND-gate of cfg_start onto bit mode_cur; no added latency.
- If mode_cur >= NUM_SRC (no source): all mux outputs, src_key and src_cfg_start are 0.
- frame_active:
  - Set on a cycle with registered ws2812_start = 1.
  - Cleared on frame_done.
  - If both occur in the same cycle, set wins.
- States:
  - RUN: if mode_req != mode_cur, go to DRAIN and assert switching. Keys to all sources are gated to 0 from this cycle.
  - DRAIN:
    - Hold the current mux so the in-flight frame completes.
    - Suppress new frame starts (ws2812_start forced 0).
    - Exit when frame_active = 0, or on the frame_done pulse, or when the timeout counter reaches FRAME_TO-1.
    - Exit target: BLANK if BLANK_EN = 1 and the new mode_req < NUM_SRC; otherwise SWITCH.
  - BLANK:
    - Pulse ws2812_start for 1 cycle on entry.
    - Each cfg_start returns cfg_data = 0 and cfg_num = blank counter, then increments the counter.
    - No src_cfg_start is forwarded.
    - Exit to SWITCH on frame_done, or on timeout.
  - SWITCH, 1 cycle:
    - mode_cur <= mode_req sampled this cycle.
    - Clear counters.
    - Go to RUN; switching deasserts on entering RUN.
- mode_req changes during DRAIN/BLANK: no restart. The value sampled in SWITCH wins. If that value equals the old mode_cur, mode_cur is unchanged but the blank frame has still been sent.
- Timeout counter: runs only in DRAIN and BLANK; saturating; cleared on every state entry.
- Key pulse in the same cycle as the RUN->DRAIN transition is dropped; it is delivered to no source.
- Reset in DRAIN or BLANK returns to RUN with mode_cur = 0 immediately. No blank completion is required.

Decomposition:
- Shared package ws2812_pkg holds:
  - state encoding (RUN, DRAIN, BLANK, SWITCH);
  - the DATA_W colour constant (COLOR_OFF = 0);
  - mode code constants MODE_MENU = 0 and MODE_DRAW = 2 (codebase mapping).
- One natural sub-module, ws2812_src_mux: purely the registered NUM_SRC-way slice mux for start/num/data.
- The FSM, counters and key gating stay in ws2812_src_arb.

Test Plan:
1. NUM_SRC=4, mode_req=0, src_start[0] pulse, src_data slice0 = 24'hFF0000 → ws2812_start high 1 cycle later, cfg_data = 24'hFF0000; other sources' data never appears.
2. key_in = 5'b00100 with mode_cur = 2 → src_key slice2 = 5'b00100 one cycle later; slices 0, 1, 3 stay 0.
3. Frame active on source 0, mode_req 0→2 mid-frame → switching = 1, no new start, frame completes from source 0. Then blank frame: all 64 cfg_start requests get cfg_data = 0 and cfg_num = 0..63. Then mode_cur = 2, switching = 0.
4. BLANK_EN = 0, mode_req 1→3 while idle (frame_active = 0) → mode_cur = 3 within 3 cycles; no ws2812_start is emitted.
5. FRAME_TO = 16, frame_done never arrives during DRAIN → forced exit after 16 cycles; the switch completes.
6. mode_req = 3'b111 with NUM_SRC = 4 (SEL_W = 3) → after the switch, all outputs are 0. Then a sys_rst pulse during BLANK → next cycle state RUN, mode_cur = 0, all outputs 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame-source arbiter: FSM encoding,
// the "all LEDs off" colour and the codebase mode-code mapping.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_BLANK  = 2'd2,
        ST_SWITCH = 2'd3
    } arb_state_t;

    // GRB colour that turns a pixel fully off.
    localparam logic [23:0] COLOR_OFF = 24'h000000;

    // Mode codes used by the rest of the codebase.
    localparam int MODE_MENU = 0;
    localparam int MODE_DRAW = 2;

endpackage

// File: rtl/ws2812_src_mux.sv
// Registered NUM_SRC-way slice mux for frame start, pixel index and colour.
// A select code with no matching source yields all-zero outputs.
module ws2812_src_mux #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int NUM_W   = 6,
    parameter int DATA_W  = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      start_en,
    input  logic [NUM_SRC-1:0]        src_start,
    input  logic [NUM_SRC*NUM_W-1:0]  src_num,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      start,
    output logic [NUM_W-1:0]          num,
    output logic [DATA_W-1:0]         data
);

    logic              start_d;
    logic [NUM_W-1:0]  num_d;
    logic [DATA_W-1:0] data_d;

    // Pick the slice of the selected source; nothing matches an out-of-range code.
    always_comb begin
        start_d = 1'b0;
        num_d   = '0;
        data_d  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                start_d = start_en & src_start[i];
                num_d   = src_num[i*NUM_W +: NUM_W];
                data_d  = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // One register stage towards the serialiser.
    always_ff @(posedge clk) begin
        if (rst) begin
            start <= 1'b0;
            num   <= '0;
            data  <= '0;
        end else begin
            start <= start_d;
            num   <= num_d;
            data  <= data_d;
        end
    end

endmodule

// File: rtl/ws2812_src_arb.sv
// Arbiter between per-mode WS2812 frame generators and the single serialiser.
// Handshake: src_start/ws2812_start and cfg_start/frame_done are single-cycle
// pulses with no back-pressure; the source must present cfg_num/cfg_data for a
// cfg_start in the same cycle it sees its src_cfg_start bit, and the arbiter
// presents them to the serialiser one cycle later.
// Source changes happen only at frame boundaries, optionally via a blank frame.
module ws2812_src_arb
    import ws2812_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int NUM_W    = 6,
    parameter int DATA_W   = 24,
    parameter int KEY_W    = 5,
    parameter int LED_NUM  = 64,
    parameter int BLANK_EN = 1,
    parameter int FRAME_TO = 2**20
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [SEL_W-1:0]          mode_req,
    input  logic [KEY_W-1:0]          key_in,
    input  logic [NUM_SRC-1:0]        src_start,
    input  logic [NUM_SRC*NUM_W-1:0]  src_num,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      cfg_start,
    input  logic                      frame_done,
    output logic [NUM_SRC-1:0]        src_cfg_start,
    output logic [NUM_SRC*KEY_W-1:0]  src_key,
    output logic                      ws2812_start,
    output logic [NUM_W-1:0]          cfg_num,
    output logic [DATA_W-1:0]         cfg_data,
    output logic [SEL_W-1:0]          mode_cur,
    output logic                      switching
);

    localparam int                TO_W       = $clog2(FRAME_TO + 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(FRAME_TO - 1);
    localparam logic [NUM_W-1:0]  BLANK_LAST = NUM_W'(LED_NUM - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              frame_active;
    logic [TO_W-1:0]   to_cnt;
    logic [NUM_W-1:0]  blank_cnt;
    logic [NUM_W-1:0]  blank_num;
    logic              blank_start;
    logic              stay_run;
    logic              req_valid;
    logic              timed_out;
    logic [SEL_W-1:0]  mux_sel;
    logic              mux_start;
    logic [NUM_W-1:0]  mux_num;
    logic [DATA_W-1:0] mux_data;

    // Normal operation: in RUN with no change requested.
    assign stay_run  = (state == ST_RUN) && (mode_req == mode_cur);
    assign req_valid = int'(mode_req) < NUM_SRC;
    assign timed_out = (to_cnt == TO_LAST);
    assign switching = (state != ST_RUN);
    // In SWITCH, pre-load the new source so RUN starts with its data.
    assign mux_sel   = (state == ST_SWITCH) ? mode_req : mode_cur;

    ws2812_src_mux #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W),
        .NUM_W   (NUM_W),
        .DATA_W  (DATA_W)
    ) u_mux (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .sel       (mux_sel),
        .start_en  (stay_run),
        .src_start (src_start),
        .src_num   (src_num),
        .src_data  (src_data),
        .start     (mux_start),
        .num       (mux_num),
        .data      (mux_data)
    );

    // The blank frame replaces the source outputs while in BLANK.
    assign ws2812_start = (state == ST_BLANK) ? blank_start : mux_start;
    assign cfg_num      = (state == ST_BLANK) ? blank_num : mux_num;
    assign cfg_data     = (state == ST_BLANK) ? DATA_W'(COLOR_OFF) : mux_data;

    // Forward pixel requests to the active source, never during the blank frame.
    always_comb begin
        src_cfg_start = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((state != ST_BLANK) && (mode_cur == SEL_W'(i))) begin
                src_cfg_start[i] = cfg_start;
            end
        end
    end

    // Next-state logic for the source-change sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (mode_req != mode_cur) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!frame_active || frame_done || timed_out) begin
                    state_next = ((BLANK_EN != 0) && req_valid) ? ST_BLANK : ST_SWITCH;
                end
            end
            ST_BLANK: begin
                if (frame_done || timed_out) state_next = ST_SWITCH;
            end
            ST_SWITCH: state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // State register and active mode code.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_RUN;
            mode_cur <= SEL_W'(MODE_MENU);
        end else begin
            state <= state_next;
            if (state == ST_SWITCH) mode_cur <= mode_req;
        end
    end

    // Track whether the serialiser is mid-frame; a new start beats a done pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_active <= 1'b0;
        end else if (ws2812_start) begin
            frame_active <= 1'b1;
        end else if (frame_done) begin
            frame_active <= 1'b0;
        end
    end

    // Saturating frame timeout, counting only in DRAIN/BLANK, restarted on each state entry.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            to_cnt <= '0;
        end else if (state_next != state) begin
            to_cnt <= '0;
        end else if (((state == ST_DRAIN) || (state == ST_BLANK)) && !timed_out) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Blank frame generator: start pulse on entry, then index per pixel request.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            blank_start <= 1'b0;
            blank_cnt   <= '0;
            blank_num   <= '0;
        end else begin
            blank_start <= (state_next == ST_BLANK) && (state != ST_BLANK);
            if ((state == ST_BLANK) && cfg_start) begin
                blank_num <= blank_cnt;
                if (blank_cnt != BLANK_LAST) blank_cnt <= blank_cnt + 1'b1;
            end
            if (((state_next == ST_BLANK) && (state != ST_BLANK)) || (state == ST_SWITCH)) begin
                blank_cnt <= '0;
                blank_num <= '0;
            end
        end
    end

    // Keys reach only the active source, and only while no change is pending.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            src_key <= '0;
        end else begin
            src_key <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (stay_run && (mode_cur == SEL_W'(i))) begin
                    src_key[i*KEY_W +: KEY_W] <= key_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_src_arb.sv
// Directed bench for ws2812_src_arb: one instance with blank frames and a long
// timeout, one without blank frames and a 16-cycle timeout.
module tb_ws2812_src_arb;
    import ws2812_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 3;
    localparam int NUM_W   = 6;
    localparam int DATA_W  = 24;
    localparam int KEY_W   = 5;
    localparam int LED_NUM = 64;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic                      sys_rst;
    logic [SEL_W-1:0]          mode_req;
    logic [KEY_W-1:0]          key_in;
    logic [NUM_SRC-1:0]        src_start;
    logic [NUM_SRC*NUM_W-1:0]  src_num;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      cfg_start;
    logic                      frame_done;

    logic [NUM_SRC-1:0]        a_src_cfg_start, b_src_cfg_start;
    logic [NUM_SRC*KEY_W-1:0]  a_src_key, b_src_key;
    logic                      a_ws2812_start, b_ws2812_start;
    logic [NUM_W-1:0]          a_cfg_num, b_cfg_num;
    logic [DATA_W-1:0]         a_cfg_data, b_cfg_data;
    logic [SEL_W-1:0]          a_mode_cur, b_mode_cur;
    logic                      a_switching, b_switching;

    ws2812_src_arb #(
        .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .NUM_W(NUM_W), .DATA_W(DATA_W),
        .KEY_W(KEY_W), .LED_NUM(LED_NUM), .BLANK_EN(1), .FRAME_TO(1024)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_req(mode_req), .key_in(key_in),
        .src_start(src_start), .src_num(src_num), .src_data(src_data),
        .cfg_start(cfg_start), .frame_done(frame_done),
        .src_cfg_start(a_src_cfg_start), .src_key(a_src_key),
        .ws2812_start(a_ws2812_start), .cfg_num(a_cfg_num), .cfg_data(a_cfg_data),
        .mode_cur(a_mode_cur), .switching(a_switching)
    );

    ws2812_src_arb #(
        .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .NUM_W(NUM_W), .DATA_W(DATA_W),
        .KEY_W(KEY_W), .LED_NUM(LED_NUM), .BLANK_EN(0), .FRAME_TO(16)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_req(mode_req), .key_in(key_in),
        .src_start(src_start), .src_num(src_num), .src_data(src_data),
        .cfg_start(cfg_start), .frame_done(frame_done),
        .src_cfg_start(b_src_cfg_start), .src_key(b_src_key),
        .ws2812_start(b_ws2812_start), .cfg_num(b_cfg_num), .cfg_data(b_cfg_data),
        .mode_cur(b_mode_cur), .switching(b_switching)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [NUM_W+DATA_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst    = 1'b1;
        mode_req   = '0;
        key_in     = '0;
        src_start  = '0;
        src_num    = '0;
        src_data   = '0;
        cfg_start  = 1'b0;
        frame_done = 1'b0;
        step();
        step();
    endtask

    // One pixel request on dut_a: the source presents n/d, the expected pixel
    // is queued at request time and compared when it reaches the serialiser side.
    task automatic pix(input int src, input logic [NUM_W-1:0] n, input logic [DATA_W-1:0] d,
                       input logic [NUM_SRC-1:0] exp_cfgs,
                       input logic [NUM_W-1:0] exp_n, input logic [DATA_W-1:0] exp_d);
        logic [NUM_W+DATA_W-1:0] want;
        src_num[src*NUM_W +: NUM_W]    = n;
        src_data[src*DATA_W +: DATA_W] = d;
        cfg_start = 1'b1;
        exp_q.push_back({exp_n, exp_d});
        #1;
        chk("src_cfg_start", 64'(a_src_cfg_start), 64'(exp_cfgs));
        step();
        cfg_start = 1'b0;
        want = exp_q.pop_front();
        chk("pixel", 64'({a_cfg_num, a_cfg_data}), 64'(want));
    endtask

    task automatic chk_a_idle(input string tag);
        chk({tag, "_start"}, 64'(a_ws2812_start), 64'd0);
        chk({tag, "_num"},   64'(a_cfg_num),      64'd0);
        chk({tag, "_data"},  64'(a_cfg_data),     64'd0);
        chk({tag, "_key"},   64'(a_src_key),      64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        logic [NUM_W-1:0]  rn;
        logic [DATA_W-1:0] rd;

        // Reset state
        do_reset();
        chk("rst_mode_cur", 64'(a_mode_cur), 64'(MODE_MENU));
        chk("rst_switching", 64'(a_switching), 64'd0);
        chk("rst_cfgs", 64'(a_src_cfg_start), 64'd0);
        chk_a_idle("rst");
        chk("rst_b_mode_cur", 64'(b_mode_cur), 64'd0);
        sys_rst = 1'b0;

        // Frame start routed from source 0 only
        src_num  = {6'd33, 6'd22, 6'd11, 6'd5};
        src_data = {24'h123456, 24'h0000FF, 24'h00FF00, 24'hFF0000};
        src_start = 4'b0001;
        step();
        src_start = 4'b0000;
        chk("t1_start", 64'(a_ws2812_start), 64'd1);
        chk("t1_data", 64'(a_cfg_data), 64'hFF0000);
        chk("t1_num", 64'(a_cfg_num), 64'd5);
        src_start = 4'b0010;
        step();
        src_start = 4'b0000;
        chk("t1_other_start", 64'(a_ws2812_start), 64'd0);
        chk("t1_hold_data", 64'(a_cfg_data), 64'hFF0000);
        for (int i = 0; i < 4; i++) begin
            rn = NUM_W'($urandom_range(0, LED_NUM - 1));
            rd = DATA_W'($urandom_range(1, 24'hFFFFFF));
            pix(0, rn, rd, 4'b0001, rn, rd);
        end

        // Mid-frame change 0 -> 2: drain, blank frame, then switch
        mode_req = 3'(MODE_DRAW);
        key_in   = 5'b00001;
        step();
        key_in = '0;
        chk("t3_switching", 64'(a_switching), 64'd1);
        chk("t3_mode_hold", 64'(a_mode_cur), 64'd0);
        chk("t3_key_dropped", 64'(a_src_key), 64'd0);
        src_start = 4'b0001;
        key_in    = 5'b00010;
        step();
        src_start = '0;
        key_in    = '0;
        chk("t3_no_start", 64'(a_ws2812_start), 64'd0);
        chk("t3_key_gated", 64'(a_src_key), 64'd0);
        for (int i = 0; i < 3; i++) begin
            rn = NUM_W'($urandom_range(0, LED_NUM - 1));
            rd = DATA_W'($urandom_range(1, 24'hFFFFFF));
            pix(0, rn, rd, 4'b0001, rn, rd);
        end
        chk("t3_still_drain", 64'(a_switching), 64'd1);
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        chk("t3_blank_start", 64'(a_ws2812_start), 64'd1);
        chk("t3_blank_num0", 64'(a_cfg_num), 64'd0);
        chk("t3_blank_data0", 64'(a_cfg_data), 64'd0);
        step();
        chk("t3_blank_pulse_end", 64'(a_ws2812_start), 64'd0);
        for (int i = 0; i < LED_NUM; i++) begin
            rd = DATA_W'($urandom_range(1, 24'hFFFFFF));
            pix(0, NUM_W'(i), rd, 4'b0000, NUM_W'(i), '0);
        end
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        chk("t3_switch_state", 64'(a_switching), 64'd1);
        step();
        chk("t3_mode_cur", 64'(a_mode_cur), 64'(MODE_DRAW));
        chk("t3_switch_done", 64'(a_switching), 64'd0);

        // Keys only to the active source (mode 2)
        key_in = 5'b00100;
        step();
        key_in = '0;
        chk("t2_key", 64'(a_src_key), 64'(20'(5'b00100) << (2 * KEY_W)));
        step();
        chk("t2_key_clear", 64'(a_src_key), 64'd0);
        rn = NUM_W'($urandom_range(0, LED_NUM - 1));
        rd = DATA_W'($urandom_range(1, 24'hFFFFFF));
        pix(2, rn, rd, 4'b0100, rn, rd);

        // No-source code 7: everything quiet
        mode_req = 3'b111;
        step();
        step();
        step();
        chk("t6_mode_cur", 64'(a_mode_cur), 64'd7);
        chk("t6_switching", 64'(a_switching), 64'd0);
        src_start = '1;
        key_in    = '1;
        src_data  = {24'hABCDEF, 24'h111111, 24'h222222, 24'h333333};
        src_num   = {6'd1, 6'd2, 6'd3, 6'd4};
        cfg_start = 1'b1;
        #1;
        chk("t6_cfgs", 64'(a_src_cfg_start), 64'd0);
        step();
        src_start = '0;
        key_in    = '0;
        cfg_start = 1'b0;
        chk_a_idle("t6_nosrc");

        // Reset while in BLANK
        mode_req = 3'd1;
        step();
        step();
        chk("t6_in_blank_sw", 64'(a_switching), 64'd1);
        chk("t6_in_blank_start", 64'(a_ws2812_start), 64'd1);
        sys_rst = 1'b1;
        step();
        chk("t6_rst_state", 64'(dut_a.state), 64'(ST_RUN));
        chk("t6_rst_mode_cur", 64'(a_mode_cur), 64'd0);
        chk("t6_rst_switching", 64'(a_switching), 64'd0);
        chk_a_idle("t6_rst");
        sys_rst = 1'b0;

        // No blank frame: idle change 1 -> 3 completes within 3 cycles
        do_reset();
        sys_rst  = 1'b0;
        mode_req = 3'd1;
        for (int i = 0; i < 4; i++) step();
        chk("t4_mode1", 64'(b_mode_cur), 64'd1);
        mode_req = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_start", 64'(b_ws2812_start), 64'd0);
        end
        chk("t4_mode3", 64'(b_mode_cur), 64'd3);
        chk("t4_switching", 64'(b_switching), 64'd0);

        // Drain timeout: frame_done never comes; 16 DRAIN cycles + 1 SWITCH
        src_start = 4'b1000;
        step();
        src_start = '0;
        mode_req  = 3'd0;
        chk("t5_start", 64'(b_ws2812_start), 64'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (b_switching) cnt++;
            else if (cnt > 0) break;
        end
        chk("t5_switch_len", 64'(cnt), 64'd17);
        chk("t5_mode_cur", 64'(b_mode_cur), 64'd0);
        chk("t5_switching", 64'(b_switching), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
